// File: rtl/ex_alu_pc_unit.sv
// Execute-stage compute core: 32-bit ALU, branch resolution and next-PC selection,
// with registered ALU outputs for the EX/MEM latch and a sticky halt that freezes the PC.
module ex_alu_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  branch_mode,
  input  logic [1:0]  pc_inc_req,
  input  logic [31:0] last_pc,
  input  logic [31:0] abs_addr,
  input  logic [31:0] branch_addr,
  input  logic        halt_req,
  output logic [31:0] result,
  output logic        zero,
  output logic [1:0]  pc_inc,
  output logic [31:0] next_pc,
  output logic [31:0] alu_result_q,
  output logic        alu_zero_q,
  output logic        halted
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;

  localparam logic [1:0] PC_NORMAL = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_STOP   = 2'b11;

  logic [31:0] alu_result_d;
  logic        alu_zero_d;
  logic        halted_q;
  logic        halted_d;
  logic        taken;
  logic [1:0]  eff;
  logic [31:0] pc_seq;
  logic [31:0] pc_calc;

  always_comb begin
    result = 32'h0;
    case (alu_op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_SLT:  result = {31'h0, $signed(a) < $signed(b)};
      OP_SLTU: result = {31'h0, a < b};
      OP_SLL:  result = a << b[4:0];
      OP_SRL:  result = a >> b[4:0];
      OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      OP_LUI:  result = {b[15:0], 16'h0000};
      default: result = 32'h0;
    endcase
  end

  assign zero = (result == 32'h0);

  // An untaken branch falls back to sequential fetch; halt forces STOP on top.
  always_comb begin
    taken = ((branch_mode == 2'b01) && zero) || ((branch_mode == 2'b10) && !zero);
    eff   = ((pc_inc_req == PC_BRANCH) && !taken) ? PC_NORMAL : pc_inc_req;
    eff   = eff | (halted_q ? PC_STOP : PC_NORMAL);
  end

  always_comb begin
    pc_seq  = last_pc + 32'd4;
    pc_calc = pc_seq;
    case (eff)
      PC_NORMAL: pc_calc = pc_seq;
      PC_BRANCH: pc_calc = pc_seq + (branch_addr << 2);
      PC_JUMP:   pc_calc = abs_addr;
      PC_STOP:   pc_calc = last_pc;
      default:   pc_calc = pc_seq;
    endcase
  end

  assign pc_inc  = clr ? PC_NORMAL : eff;
  assign next_pc = clr ? RESET_PC : pc_calc;

  always_comb begin
    alu_result_d = result;
    alu_zero_d   = zero;
    halted_d     = halted_q | halt_req;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      alu_result_q <= 32'h0;
      alu_zero_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      alu_result_q <= alu_result_d;
      alu_zero_q   <= alu_zero_d;
      halted_q     <= halted_d;
    end
  end

  assign halted = halted_q;

endmodule

// File: tb/tb_ex_alu_pc_unit.sv
// Directed bench for ex_alu_pc_unit: ALU ops, branch/jump/next-PC selection,
// registered outputs, sticky halt and clear priority.
module tb_ex_alu_pc_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  alu_op;
  logic [31:0] a, b;
  logic [1:0]  branch_mode;
  logic [1:0]  pc_inc_req;
  logic [31:0] last_pc, abs_addr, branch_addr;
  logic        halt_req;
  logic [31:0] result;
  logic        zero;
  logic [1:0]  pc_inc;
  logic [31:0] next_pc;
  logic [31:0] alu_result_q;
  logic        alu_zero_q;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_alu_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .clr(clr), .alu_op(alu_op), .a(a), .b(b),
    .branch_mode(branch_mode), .pc_inc_req(pc_inc_req), .last_pc(last_pc),
    .abs_addr(abs_addr), .branch_addr(branch_addr), .halt_req(halt_req),
    .result(result), .zero(zero), .pc_inc(pc_inc), .next_pc(next_pc),
    .alu_result_q(alu_result_q), .alu_zero_q(alu_zero_q), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    alu_op = op; a = va; b = vb;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; alu_op = 4'd0; a = 32'd1; b = 32'd2;
    branch_mode = 2'b00; pc_inc_req = 2'b10; last_pc = 32'h100;
    abs_addr = 32'h400; branch_addr = 32'h0; halt_req = 1'b1;
    #1;
    chk("clr_next_pc", next_pc, 32'h0);
    chk("clr_pc_inc", {30'h0, pc_inc}, 32'h0);
    tick;
    chk("rst_alu_result_q", alu_result_q, 32'h0);
    chk("rst_alu_zero_q", {31'h0, alu_zero_q}, 32'h0);
    chk("rst_halted_clr_prio", {31'h0, halted}, 32'h0);

    clr = 1'b0; halt_req = 1'b0; pc_inc_req = 2'b00;
    alu(4'd0, 32'h7FFF_FFFF, 32'h1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_zero", {31'h0, zero}, 32'h0);
    tick;
    chk("add_result_q", alu_result_q, 32'h8000_0000);
    alu(4'd1, 32'd5, 32'd5);
    chk("sub_result", result, 32'h0);
    chk("sub_zero", {31'h0, zero}, 32'h1);
    tick;
    chk("sub_zero_q", {31'h0, alu_zero_q}, 32'h1);
    chk("sub_result_q", alu_result_q, 32'h0);

    alu(4'd6, 32'hFFFF_FFFF, 32'h1);   chk("slt", result, 32'h1);
    alu(4'd7, 32'hFFFF_FFFF, 32'h1);   chk("sltu", result, 32'h0);
    alu(4'd10, 32'h8000_0000, 32'd4);  chk("sra", result, 32'hF800_0000);
    alu(4'd9, 32'h8000_0000, 32'd4);   chk("srl", result, 32'h0800_0000);
    alu(4'd8, 32'h0000_0003, 32'd31);  chk("sll", result, 32'h8000_0000);
    alu(4'd11, 32'h0, 32'h1234);       chk("lui", result, 32'h1234_0000);
    alu(4'd5, 32'h0F0F_0000, 32'h0000_00F0); chk("nor", result, 32'hF0F0_FF0F);
    alu(4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0); chk("xor", result, 32'hF0F0_F0F0);
    alu(4'd13, 32'h1, 32'h1);          chk("op13_zero", result, 32'h0);
    chk("op13_zero_flag", {31'h0, zero}, 32'h1);

    branch_mode = 2'b01; pc_inc_req = 2'b01; last_pc = 32'h100; branch_addr = 32'hFFFF_FFFE;
    alu(4'd1, 32'd3, 32'd3);
    chk("beq_taken_pc_inc", {30'h0, pc_inc}, 32'h1);
    chk("beq_taken_next_pc", next_pc, 32'hFC);
    alu(4'd1, 32'd3, 32'd4);
    chk("beq_not_pc_inc", {30'h0, pc_inc}, 32'h0);
    chk("beq_not_next_pc", next_pc, 32'h104);
    branch_mode = 2'b10; #1;
    chk("bne_taken_next_pc", next_pc, 32'hFC);
    branch_mode = 2'b00; #1;
    chk("nobranch_pc_inc", {30'h0, pc_inc}, 32'h0);

    pc_inc_req = 2'b10; abs_addr = 32'h400; #1;
    chk("jump_pc_inc", {30'h0, pc_inc}, 32'h2);
    chk("jump_next_pc", next_pc, 32'h400);
    pc_inc_req = 2'b00; last_pc = 32'hFFFF_FFFC; #1;
    chk("normal_wrap", next_pc, 32'h0);
    pc_inc_req = 2'b11; last_pc = 32'h300; #1;
    chk("stop_req_next_pc", next_pc, 32'h300);

    pc_inc_req = 2'b00; last_pc = 32'h200; halt_req = 1'b1; #1;
    chk("pre_halt_halted", {31'h0, halted}, 32'h0);
    chk("pre_halt_next_pc", next_pc, 32'h204);
    tick;
    halt_req = 1'b0; #1;
    chk("halt_halted", {31'h0, halted}, 32'h1);
    chk("halt_pc_inc", {30'h0, pc_inc}, 32'h3);
    chk("halt_next_pc", next_pc, 32'h200);
    pc_inc_req = 2'b10; #1;
    chk("halt_jump_masked", next_pc, 32'h200);
    tick;
    chk("halt_sticky", {31'h0, halted}, 32'h1);

    clr = 1'b1; halt_req = 1'b1; alu(4'd0, 32'h10, 32'h20);
    chk("clr_next_pc_2", next_pc, 32'h0);
    chk("clr_pc_inc_2", {30'h0, pc_inc}, 32'h0);
    tick;
    chk("clr_halt_prio", {31'h0, halted}, 32'h0);
    chk("clr_alu_result_q", alu_result_q, 32'h0);
    chk("clr_alu_zero_q", {31'h0, alu_zero_q}, 32'h0);
    clr = 1'b0; halt_req = 1'b0; pc_inc_req = 2'b00; last_pc = 32'h200; #1;
    chk("post_clr_next_pc", next_pc, 32'h204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu_pc_unit.md
Name: ex_alu_pc_unit

Overview:
Execute-stage compute core of the MIPS pipeline. It combines a 32-bit ALU and a next-PC calculator: operand A/B in, combinational result/zero, branch resolution and next-PC selection. ALU outputs are also registered for the EX/MEM latch. A sticky halt mask freezes the PC after a halt request (syscall exit) until reset.

Parameters:
RESET_PC, 32'h00000000, next_pc value driven while clr is high

Ports:
clk  in  1  system clock; all state updates on rising edge
clr  in  1  synchronous active-high reset
alu_op  in  4  ALU operation code
a  in  32  operand A (shift source for shift ops)
b  in  32  operand B (b[4:0] = shift amount for shift ops)
branch_mode  in  2  00 none, 01 BEQ (taken if zero), 10 BNE (taken if !zero), 11 none
pc_inc_req  in  2  requested PC mode: 00 NORMAL, 01 BRANCH, 10 JUMP, 11 STOP
last_pc  in  32  PC of the instruction in EX
abs_addr  in  32  absolute jump target
branch_addr  in  32  sign-extended branch word offset
halt_req  in  1  request to set sticky halt
result  out  32  combinational ALU result
zero  out  1  combinational, result == 0
pc_inc  out  2  effective PC mode (combinational)
next_pc  out  32  combinational next PC
alu_result_q  out  32  registered result
alu_zero_q  out  1  registered zero
halted  out  1  sticky halt flag

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high.
- ALU ops (combinational, 32-bit wrap, no overflow trap). 0 ADD a+b. 1 SUB a-b. 2 AND. 3 OR. 4 XOR. 5 NOR ~(a|b). 6 SLT signed a<b ->1/0. 7 SLTU unsigned. 8 SLL a<<b[4:0]. 9 SRL logical a>>b[4:0]. 10 SRA arithmetic a>>>b[4:0]. 11 LUI {b[15:0],16'h0}. 12-15: result = 0.
- zero = (result == 32'h0).
- taken = (branch_mode==01 & zero) | (branch_mode==10 & !zero).
- eff = (pc_inc_req==01 & !taken) ? 00 : pc_inc_req; then eff |= (halted ? 2'b11 : 2'b00).
- pc_inc = clr ? 00 : eff.
- PC calc by eff: 00 -> last_pc+4. 01 -> last_pc+4+(branch_addr<<2), 32-bit wrap. 10 -> abs_addr. 11 -> last_pc (hold).
- next_pc = clr ? RESET_PC : calculated value.
- Registers on posedge clk:
  - clr=1: alu_result_q=0, alu_zero_q=0, halted=0. Clear has priority over halt_req in the same cycle.
  - Otherwise: alu_result_q<=result, alu_zero_q<=zero. halted<=halted|halt_req.
- Latency: result, zero, pc_inc and next_pc are combinational, 0 cycles. _q outputs have 1-cycle latency. halted affects pc_inc and next_pc from the cycle after halt_req is sampled.
- Power-up: all registers 0.
- halted is sticky and cleared only by clr.

Test Plan:
- ADD a=7FFFFFFF, b=1 -> result 80000000, zero 0. SUB a=5, b=5 -> result 0, zero 1, alu_zero_q=1 next edge.
- SLT a=FFFFFFFF, b=1 -> 1; SLTU same operands -> 0. SRA a=80000000, b=4 -> F8000000. SRL same -> 08000000. LUI b=1234 -> 12340000.
- BEQ with pc_inc_req=01, last_pc=100, branch_addr=FFFFFFFE, a=b=3 -> pc_inc 01, next_pc FC. With a=3, b=4 -> pc_inc 00, next_pc 104.
- JUMP pc_inc_req=10, abs_addr=400 -> next_pc 400. NORMAL with last_pc=FFFFFFFC -> next_pc 0 (wrap).
- halt_req pulse, then pc_inc_req=00, last_pc=200 -> next cycle pc_inc 11, next_pc 200, halted 1. Persists until clr. clr+halt_req same edge -> halted 0.
- clr high -> next_pc 0, pc_inc 00 regardless of inputs. After edge alu_result_q=0, alu_zero_q=0.
